pipeline_hazard_controller: RTL
===============================

// Module: pipeline_hazard_controller
// PURPOSE
//  Sequencing controller for the 5-stage ARM pipeline.
//  - Drives PC_enable and IF_ID_Enable.
//  - Drives the cu_mux NOP-select, which zeroes the control signals into ID/EX.
//  - Drives the IF/ID flush and the per-stage pipeline-register enables.
//  - Resolves load-use stalls, taken-branch flushes and data-memory busy freezes.
//  - Produces EX-stage operand forwarding selects and saturating stall/flush counters.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (1..7)
//  FLUSH_CYCLES       1   cycles IF/ID is flushed after a taken branch (1..7)
//  CNT_W              16  width of the performance counters
// PORTS
//  clk               in   1      system clock, rising edge
//  reset             in   1      asynchronous, active-high
//  id_rn, id_rm      in   4      source registers of the instruction in ID
//  id_rn_used        in   1      ID instruction reads Rn
//  id_rm_used        in   1      ID instruction reads Rm
//  branch_taken      in   1      PCSrc from ID (taken B/BL)
//  ex_rd             in   4      destination register in EX
//  ex_reg_write      in   1      ID_EX_RegWrite
//  ex_load           in   1      ID_EX_MemtoReg (load in EX)
//  mem_rd            in   4      destination register in MEM
//  mem_reg_write     in   1      EX_MEM_RegWrite
//  wb_rd             in   4      destination register in WB
//  wb_reg_write      in   1      MEM_WB_RegWrite
//  mem_busy          in   1      data memory not ready; freeze the whole pipe
//  pc_enable         out  1      PC load enable
//  if_id_enable      out  1      IF/ID load enable
//  if_id_flush       out  1      IF/ID loads 32'h0 (NOP) at the next edge
//  cu_nop_select     out  1      1 = cu_mux outputs all-zero control
//  back_enable       out  1      enable for ID/EX, EX/MEM and MEM/WB
//  fwd_a, fwd_b      out  2      00 = register file, 01 = WB, 10 = MEM
//  stall_count       out  CNT_W  cycles with pc_enable = 0
//  flush_count       out  CNT_W  cycles with if_id_flush = 1
// BEHAVIOUR
//  Reset (async, active-high)
//  - State = RUN, counters = 0, internal down-counter = 0.
//  - Outputs: pc_enable = 1, if_id_enable = 1, back_enable = 1,
//    if_id_flush = 0, cu_nop_select = 0, fwd_a = fwd_b = 00.
//  - Reset asserted mid-stall or mid-flush returns to RUN immediately.
//  Hazard terms (combinational)
//  - luh = ex_load & ex_reg_write & ex_rd != 15 &
//    ((id_rn_used & id_rn == ex_rd) | (id_rm_used & id_rm == ex_rd)).
//  FSM: RUN, LSTALL, FLUSH. Priority: mem_busy > load-use > branch.
//  - mem_busy = 1, any state:
//    - all enables = 0, flush = 0, nop = 0.
//    - State and down-counter hold; counters do not increment.
//  - RUN, luh:
//    - pc_enable = if_id_enable = 0, cu_nop_select = 1.
//    - If LOAD_STALL_CYCLES > 1: go to LSTALL, cnt = LOAD_STALL_CYCLES - 1.
//    - branch_taken is ignored this cycle; ID holds, so it is re-evaluated.
//  - RUN, branch_taken & !luh:
//    - pc_enable = 1 (PC takes the target), if_id_flush = 1.
//    - If FLUSH_CYCLES > 1: go to FLUSH, cnt = FLUSH_CYCLES - 1.
//  - LSTALL:
//    - Same outputs as the RUN/luh cycle; cnt decrements each cycle.
//    - cnt reaching 1 -> RUN at the next edge.
//  - FLUSH:
//    - if_id_flush = 1, pc_enable = 1; cnt decrements.
//    - cnt reaching 1 -> RUN; branch_taken in FLUSH is ignored (ID holds a NOP).
//  - if_id_flush and if_id_enable are never both 0 while flush = 1;
//    flush overrides the IF/ID data.
//  Forwarding (combinational, not frozen by mem_busy)
//  - fwd_a = 10 if mem_reg_write & mem_rd == id_rn & mem_rd != 15;
//    else 01 if the same test holds on wb_*; else 00.
//  - MEM has priority over WB. fwd_b is the same using id_rm.
//  Counters
//  - Increment on clock edges where the condition held; saturate at all-ones.
// TESTING
//  - Reset: assert reset 3 cycles -> enables = 1, flush = nop = 0, counters = 0.
//  - Load-use: ex_load = 1, ex_rd = 2, id_rm = 2, id_rm_used = 1 -> one cycle of
//    pc_enable = 0, nop = 1; then RUN; stall_count = 1.
//  - Branch: branch_taken = 1 in RUN -> if_id_flush = 1 one cycle; flush_count = 1;
//    with FLUSH_CYCLES = 3 -> flush held 3 cycles.
//  - Simultaneous: luh and branch_taken together -> stall only, flush = 0;
//    branch taken after the stall releases.
//  - Freeze: mem_busy = 1 for 4 cycles during LSTALL (LOAD_STALL_CYCLES = 3) ->
//    all enables 0, cnt held; stall resumes afterwards.
//  - Forwarding: mem_rd = wb_rd = 5, both writing, id_rn = 5 -> fwd_a = 10;
//    rd = 15 -> fwd_a = 00.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - hazard sequencing controller for the 5-stage ARM pipeline
//
// Purpose:
//   Drives the pipeline-register enables, the IF/ID flush and the cu_mux NOP
//   select. It resolves load-use stalls, taken-branch flushes and data-memory
//   busy freezes. It also produces the EX operand forwarding selects and the
//   saturating stall and flush performance counters.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   id_rn/id_rm, *_used         source registers of the ID instruction and their use flags
//   branch_taken                taken B/BL resolved in ID
//   ex_rd/ex_reg_write/ex_load  destination, write enable and load flag of the EX instruction
//   mem_rd/mem_reg_write        destination and write enable of the MEM instruction
//   wb_rd/wb_reg_write          destination and write enable of the WB instruction
//   mem_busy                    data memory not ready, freeze the whole pipe
//   pc_enable, if_id_enable     front-end load enables
//   if_id_flush                 IF/ID loads a NOP at the next edge
//   cu_nop_select               zero the control signals going into ID/EX
//   back_enable                 enable for ID/EX, EX/MEM and MEM/WB
//   fwd_a, fwd_b                00 = register file, 01 = WB, 10 = MEM
//   stall_count, flush_count    saturating counts of stall and flush cycles

module pipeline_hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic             branch_taken,
    input  logic [3:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_load,
    input  logic [3:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [3:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             mem_busy,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             cu_nop_select,
    output logic             back_enable,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // The cycle that detects the hazard is the first bubble or flush, so
    // the down-counter covers only the remaining cycles.
    localparam logic [2:0]       LSTALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0]       FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             luh;

    // A write to r15 never creates a dependency because the PC is not forwarded.
    always_comb begin
        luh = ex_load && ex_reg_write && (ex_rd != 4'hf) &&
              ((id_rn_used && (id_rn == ex_rd)) || (id_rm_used && (id_rm == ex_rd)));
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        cu_nop_select = 1'b0;
        back_enable   = 1'b1;

        if (mem_busy) begin
            // Freeze everything. State and down-counter hold so the
            // interrupted stall or flush resumes where it left off.
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            back_enable  = 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (luh) begin
                        // ID holds, so a simultaneous branch is re-evaluated
                        // once the bubble has been inserted.
                        pc_enable     = 1'b0;
                        if_id_enable  = 1'b0;
                        cu_nop_select = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = ST_LSTALL;
                            cnt_d   = LSTALL_INIT;
                        end
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end
                    end
                end
                ST_LSTALL: begin
                    pc_enable     = 1'b0;
                    if_id_enable  = 1'b0;
                    cu_nop_select = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_FLUSH: begin
                    // ID holds a NOP here, so branch_taken is ignored.
                    if_id_flush = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // Busy cycles are excluded from the counters even though pc_enable is low.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!mem_busy && !pc_enable && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
        if (if_id_flush && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end
    end

    // Forwarding follows the live register numbers and is not frozen by mem_busy.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_reg_write && (mem_rd == id_rn) && (mem_rd != 4'hf)) begin
            fwd_a = 2'b10;
        end else if (wb_reg_write && (wb_rd == id_rn) && (wb_rd != 4'hf)) begin
            fwd_a = 2'b01;
        end

        fwd_b = 2'b00;
        if (mem_reg_write && (mem_rd == id_rm) && (mem_rd != 4'hf)) begin
            fwd_b = 2'b10;
        end else if (wb_reg_write && (wb_rd == id_rm) && (wb_rd != 4'hf)) begin
            fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= 3'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
